// File: rtl/ffstdp_update_pipe.sv
// Three-stage STDP weight update: LUT derivative x pre count, shift,
// signed saturating add onto the current weight, with a saturation counter.
module ffstdp_update_pipe #(
    parameter int LANES          = 4,
    parameter int WEIGHT_WIDTH   = 8,
    parameter int PRE_CNT_WIDTH  = 8,
    parameter int POST_CNT_WIDTH = 7,
    parameter int CNT_ACT_WIDTH  = 5
) (
    input  logic                              CLK,
    input  logic                              RST,
    input  logic                              IN_VALID,
    output logic                              IN_READY,
    input  logic                              IS_POS,
    input  logic [POST_CNT_WIDTH-1:0]         POST_SPIKE_CNT,
    input  logic [2:0]                        LR_SHIFT,
    input  logic [LANES*PRE_CNT_WIDTH-1:0]    PRE_SPIKE_CNT,
    input  logic [LANES*WEIGHT_WIDTH-1:0]     WSYN_CURR,
    input  logic [LANES-1:0]                  LANE_EN,
    input  logic                              LUT_WE,
    input  logic                              LUT_SEL,
    input  logic [CNT_ACT_WIDTH-1:0]          LUT_ADDR,
    input  logic [WEIGHT_WIDTH-1:0]           LUT_WDATA,
    output logic                              OUT_VALID,
    input  logic                              OUT_READY,
    output logic [LANES*WEIGHT_WIDTH-1:0]     WSYN_NEW,
    output logic [LANES-1:0]                  SAT_FLAG,
    input  logic                              SAT_CNT_CLR,
    output logic [15:0]                       SAT_CNT
);

    localparam int W     = WEIGHT_WIDTH;
    localparam int A     = CNT_ACT_WIDTH;
    localparam int P     = W + A;
    localparam int DEPTH = 1 << A;

    localparam logic [A-1:0] CMAX = '1;
    localparam logic [W-1:0] WMAX = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0] WMIN = {1'b1, {(W-1){1'b0}}};

    logic [LANES-1:0][PRE_CNT_WIDTH-1:0] pre_in;
    logic [LANES-1:0][W-1:0]             w_in;

    assign pre_in = PRE_SPIKE_CNT;
    assign w_in   = WSYN_CURR;

    logic [W-1:0] lut_pos_q [DEPTH];
    logic [W-1:0] lut_pos_d [DEPTH];
    logic [W-1:0] lut_neg_q [DEPTH];
    logic [W-1:0] lut_neg_d [DEPTH];

    logic                      s1_valid_q, s1_valid_d;
    logic                      s1_pos_q, s1_pos_d;
    logic [2:0]                s1_lr_q, s1_lr_d;
    logic [LANES-1:0]          s1_en_q, s1_en_d;
    logic [LANES-1:0][W-1:0]   s1_w_q, s1_w_d;
    logic [W-1:0]              s1_deriv_q, s1_deriv_d;
    logic [LANES-1:0][A-1:0]   s1_pre_q, s1_pre_d;

    logic                      s2_valid_q, s2_valid_d;
    logic                      s2_pos_q, s2_pos_d;
    logic [2:0]                s2_lr_q, s2_lr_d;
    logic [LANES-1:0]          s2_en_q, s2_en_d;
    logic [LANES-1:0][W-1:0]   s2_w_q, s2_w_d;
    logic [LANES-1:0][P-1:0]   s2_prod_q, s2_prod_d;

    logic                      out_valid_q, out_valid_d;
    logic [LANES-1:0][W-1:0]   wsyn_new_q, wsyn_new_d;
    logic [LANES-1:0]          sat_flag_q, sat_flag_d;
    logic [15:0]               sat_cnt_q, sat_cnt_d;

    logic                      en;
    logic                      hs;
    logic [A-1:0]              lut_idx;
    logic [LANES-1:0][P-1:0]   shifted;
    logic [LANES-1:0][W-1:0]   mag;
    logic [LANES-1:0][W:0]     delta;
    logic [LANES-1:0][W:0]     sum;
    logic [LANES-1:0][W-1:0]   res;
    logic [LANES-1:0]          res_sat;
    logic [16:0]               cnt_acc;

    assign en = !out_valid_q || OUT_READY;
    assign hs = out_valid_q && OUT_READY;

    // LUT lives outside reset so tables survive RST and still take writes.
    always_comb begin
        lut_pos_d = lut_pos_q;
        lut_neg_d = lut_neg_q;
        if (LUT_WE) begin
            if (LUT_SEL) lut_pos_d[LUT_ADDR] = LUT_WDATA;
            else         lut_neg_d[LUT_ADDR] = LUT_WDATA;
        end
    end

    always_ff @(posedge CLK) begin
        lut_pos_q <= lut_pos_d;
        lut_neg_q <= lut_neg_d;
    end

    always_comb begin
        lut_idx = POST_SPIKE_CNT[A-1:0];
        if (POST_SPIKE_CNT > POST_CNT_WIDTH'(CMAX)) lut_idx = CMAX;
    end

    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            shifted[l] = (s2_prod_q[l] >> (W - 1)) >> s2_lr_q;
            if (shifted[l] > P'(WMAX)) mag[l] = WMAX;
            else                       mag[l] = shifted[l][W-1:0];
            if (s2_pos_q) delta[l] = {1'b0, mag[l]};
            else          delta[l] = -{1'b0, mag[l]};
            sum[l] = {s2_w_q[l][W-1], s2_w_q[l]} + delta[l];
            // Overflow of the W-bit range shows as disagreeing top bits.
            if (!s2_en_q[l]) begin
                res[l]     = s2_w_q[l];
                res_sat[l] = 1'b0;
            end else if (sum[l][W] != sum[l][W-1]) begin
                res[l]     = sum[l][W] ? WMIN : WMAX;
                res_sat[l] = 1'b1;
            end else begin
                res[l]     = sum[l][W-1:0];
                res_sat[l] = 1'b0;
            end
        end
    end

    always_comb begin
        cnt_acc = {1'b0, sat_cnt_q};
        for (int l = 0; l < LANES; l++) begin
            cnt_acc = cnt_acc + 17'(sat_flag_q[l]);
        end
    end

    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_pos_d    = s1_pos_q;
        s1_lr_d     = s1_lr_q;
        s1_en_d     = s1_en_q;
        s1_w_d      = s1_w_q;
        s1_deriv_d  = s1_deriv_q;
        s1_pre_d    = s1_pre_q;
        s2_valid_d  = s2_valid_q;
        s2_pos_d    = s2_pos_q;
        s2_lr_d     = s2_lr_q;
        s2_en_d     = s2_en_q;
        s2_w_d      = s2_w_q;
        s2_prod_d   = s2_prod_q;
        out_valid_d = out_valid_q;
        wsyn_new_d  = wsyn_new_q;
        sat_flag_d  = sat_flag_q;
        sat_cnt_d   = sat_cnt_q;

        if (en) begin
            s1_valid_d = IN_VALID;
            s1_pos_d   = IS_POS;
            s1_lr_d    = LR_SHIFT;
            s1_en_d    = LANE_EN;
            s1_w_d     = w_in;
            s1_deriv_d = IS_POS ? lut_pos_q[lut_idx] : lut_neg_q[lut_idx];
            for (int l = 0; l < LANES; l++) begin
                s1_pre_d[l] = pre_in[l][A-1:0];
                if (pre_in[l] > PRE_CNT_WIDTH'(CMAX)) s1_pre_d[l] = CMAX;
            end

            s2_valid_d = s1_valid_q;
            s2_pos_d   = s1_pos_q;
            s2_lr_d    = s1_lr_q;
            s2_en_d    = s1_en_q;
            s2_w_d     = s1_w_q;
            for (int l = 0; l < LANES; l++) begin
                s2_prod_d[l] = P'(s1_deriv_q) * P'(s1_pre_q[l]);
            end

            out_valid_d = s2_valid_q;
            wsyn_new_d  = res;
            sat_flag_d  = res_sat;
        end

        if (SAT_CNT_CLR)  sat_cnt_d = '0;
        else if (hs)      sat_cnt_d = cnt_acc[16] ? 16'hFFFF : cnt_acc[15:0];
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            s1_valid_q  <= 1'b0;
            s1_pos_q    <= 1'b0;
            s1_lr_q     <= '0;
            s1_en_q     <= '0;
            s1_w_q      <= '0;
            s1_deriv_q  <= '0;
            s1_pre_q    <= '0;
            s2_valid_q  <= 1'b0;
            s2_pos_q    <= 1'b0;
            s2_lr_q     <= '0;
            s2_en_q     <= '0;
            s2_w_q      <= '0;
            s2_prod_q   <= '0;
            out_valid_q <= 1'b0;
            wsyn_new_q  <= '0;
            sat_flag_q  <= '0;
            sat_cnt_q   <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_pos_q    <= s1_pos_d;
            s1_lr_q     <= s1_lr_d;
            s1_en_q     <= s1_en_d;
            s1_w_q      <= s1_w_d;
            s1_deriv_q  <= s1_deriv_d;
            s1_pre_q    <= s1_pre_d;
            s2_valid_q  <= s2_valid_d;
            s2_pos_q    <= s2_pos_d;
            s2_lr_q     <= s2_lr_d;
            s2_en_q     <= s2_en_d;
            s2_w_q      <= s2_w_d;
            s2_prod_q   <= s2_prod_d;
            out_valid_q <= out_valid_d;
            wsyn_new_q  <= wsyn_new_d;
            sat_flag_q  <= sat_flag_d;
            sat_cnt_q   <= sat_cnt_d;
        end
    end

    assign IN_READY  = en;
    assign OUT_VALID = out_valid_q;
    assign WSYN_NEW  = wsyn_new_q;
    assign SAT_FLAG  = sat_flag_q;
    assign SAT_CNT   = sat_cnt_q;

endmodule

// File: tb/tb_ffstdp_update_pipe.sv
// Scoreboard bench for ffstdp_update_pipe: directed vectors queue their
// expected results, a negedge monitor pops and compares on each handshake.
module tb_ffstdp_update_pipe;

    logic        clk;
    logic        RST;
    logic        IN_VALID;
    logic        IN_READY;
    logic        IS_POS;
    logic [6:0]  POST_SPIKE_CNT;
    logic [2:0]  LR_SHIFT;
    logic [31:0] PRE_SPIKE_CNT;
    logic [31:0] WSYN_CURR;
    logic [3:0]  LANE_EN;
    logic        LUT_WE;
    logic        LUT_SEL;
    logic [4:0]  LUT_ADDR;
    logic [7:0]  LUT_WDATA;
    logic        OUT_VALID;
    logic        OUT_READY;
    logic [31:0] WSYN_NEW;
    logic [3:0]  SAT_FLAG;
    logic        SAT_CNT_CLR;
    logic [15:0] SAT_CNT;

    ffstdp_update_pipe dut (
        .CLK(clk), .RST(RST),
        .IN_VALID(IN_VALID), .IN_READY(IN_READY),
        .IS_POS(IS_POS), .POST_SPIKE_CNT(POST_SPIKE_CNT),
        .LR_SHIFT(LR_SHIFT), .PRE_SPIKE_CNT(PRE_SPIKE_CNT),
        .WSYN_CURR(WSYN_CURR), .LANE_EN(LANE_EN),
        .LUT_WE(LUT_WE), .LUT_SEL(LUT_SEL),
        .LUT_ADDR(LUT_ADDR), .LUT_WDATA(LUT_WDATA),
        .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
        .WSYN_NEW(WSYN_NEW), .SAT_FLAG(SAT_FLAG),
        .SAT_CNT_CLR(SAT_CNT_CLR), .SAT_CNT(SAT_CNT)
    );

    typedef struct {
        logic [31:0] w;
        logic [3:0]  f;
        int          acc;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc   = 0;
    bit   bp_on = 0;
    bit   rdy_req = 1;

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        OUT_READY = 1;
        forever begin
            @(posedge clk);
            #2;
            OUT_READY = bp_on ? 1'($urandom_range(0, 1)) : rdy_req;
        end
    end

    function automatic logic [31:0] pk(input int l0, l1, l2, l3);
        return {8'(l3), 8'(l2), 8'(l1), 8'(l0)};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Monitor: stall stability, in-order payload, first-output latency.
    initial begin
        bit          stall_prev;
        logic [31:0] prev_w;
        logic [3:0]  prev_f;
        exp_t        e;
        stall_prev = 0;
        prev_w = '0;
        prev_f = '0;
        forever begin
            @(negedge clk);
            if (RST) begin
                stall_prev = 0;
            end else begin
                if (stall_prev) begin
                    n_cmp++;
                    if (OUT_VALID !== 1'b1 || WSYN_NEW !== prev_w ||
                        SAT_FLAG !== prev_f) begin
                        n_err++;
                        $display("FAIL stall_hold: got v=%b w=%h f=%b expected v=1 w=%h f=%b",
                                 OUT_VALID, WSYN_NEW, SAT_FLAG, prev_w, prev_f);
                    end
                end
                if (OUT_VALID && OUT_READY) begin
                    if (q.size() == 0) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL unexpected_out: got w=%h expected no output",
                                 WSYN_NEW);
                    end else begin
                        e = q.pop_front();
                        n_cmp++;
                        if (WSYN_NEW !== e.w || SAT_FLAG !== e.f) begin
                            n_err++;
                            $display("FAIL result: got w=%h f=%b expected w=%h f=%b",
                                     WSYN_NEW, SAT_FLAG, e.w, e.f);
                        end
                        if (e.acc >= 0) begin
                            n_cmp++;
                            if (cyc - e.acc != 3) begin
                                n_err++;
                                $display("FAIL latency: got %0d expected 3",
                                         cyc - e.acc);
                            end
                        end
                    end
                end
                stall_prev = OUT_VALID && !OUT_READY;
                prev_w = WSYN_NEW;
                prev_f = SAT_FLAG;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic lut_wr(input logic sel, input logic [4:0] a,
                          input logic [7:0] d);
        LUT_WE = 1;
        LUT_SEL = sel;
        LUT_ADDR = a;
        LUT_WDATA = d;
        tick(1);
        LUT_WE = 0;
    endtask

    task automatic send(input logic pos, input logic [6:0] post,
                        input logic [2:0] lr, input logic [31:0] pre,
                        input logic [31:0] ws, input logic [3:0] en,
                        input logic [31:0] ew, input logic [3:0] ef,
                        input bit lat, input bit push);
        exp_t e;
        bit   ok;
        IN_VALID = 1;
        IS_POS = pos;
        POST_SPIKE_CNT = post;
        LR_SHIFT = lr;
        PRE_SPIKE_CNT = pre;
        WSYN_CURR = ws;
        LANE_EN = en;
        ok = 0;
        for (int i = 0; i < 1000 && !ok; i++) begin
            @(negedge clk);
            if (IN_READY) begin
                ok = 1;
                if (push) begin
                    e.w = ew;
                    e.f = ef;
                    e.acc = lat ? cyc : -1;
                    q.push_back(e);
                end
            end
            tick(1);
        end
        if (!ok) begin
            n_cmp++;
            n_err++;
            $display("FAIL accept_timeout: got no IN_READY expected accept");
        end
        IN_VALID = 0;
    endtask

    task automatic drain();
        bit done;
        done = 0;
        for (int i = 0; i < 300 && !done; i++) begin
            @(negedge clk);
            if (q.size() == 0 && !OUT_VALID) done = 1;
        end
        if (!done) begin
            n_cmp++;
            n_err++;
            $display("FAIL drain_timeout: got %0d pending expected 0", q.size());
        end
        tick(1);
    endtask

    logic [31:0] p31;
    logic [31:0] wb;

    initial begin
        RST = 1;
        IN_VALID = 0;
        IS_POS = 0;
        POST_SPIKE_CNT = '0;
        LR_SHIFT = '0;
        PRE_SPIKE_CNT = '0;
        WSYN_CURR = '0;
        LANE_EN = '0;
        LUT_WE = 0;
        LUT_SEL = 0;
        LUT_ADDR = '0;
        LUT_WDATA = '0;
        SAT_CNT_CLR = 0;
        p31 = pk(31, 31, 31, 31);
        wb  = pk(100, 0, -100, 127);
        tick(2);
        lut_wr(1, 31, 8'h80);
        tick(1);
        RST = 0;
        chk("rst_out_valid", 32'(OUT_VALID), 32'd0);
        chk("rst_wsyn_new", WSYN_NEW, 32'd0);
        chk("rst_sat_flag", 32'(SAT_FLAG), 32'd0);
        chk("rst_sat_cnt", 32'(SAT_CNT), 32'd0);
        chk("rst_in_ready", 32'(IN_READY), 32'd1);
        lut_wr(0, 10, 8'd64);
        lut_wr(1, 20, 8'h40);

        // +31 on every lane, two lanes clip
        send(1, 31, 0, p31, wb, 4'hF,
             pk(127, 31, -69, 127), 4'b1001, 1, 1);
        drain();
        chk("sat_cnt_basic", 32'(SAT_CNT), 32'd2);

        // 64*10 >> 8 = 2, subtracted
        send(0, 10, 1, pk(10, 10, 10, 10), pk(10, -127, 0, -128), 4'hF,
             pk(8, -128, -2, -128), 4'b1010, 1, 1);
        drain();
        chk("sat_cnt_neg", 32'(SAT_CNT), 32'd4);

        // post 100 -> idx 31, pre 200 -> 31
        send(1, 100, 0, pk(200, 31, 5, 0), pk(0, 1, 2, 3), 4'hF,
             pk(31, 32, 7, 3), 4'b0000, 1, 1);
        send(1, 31, 0, p31, wb, 4'b0101,
             pk(127, 0, -69, 127), 4'b0001, 0, 1);
        drain();
        chk("sat_cnt_mask", 32'(SAT_CNT), 32'd5);

        // write pos[20]=0xFF in the accept cycle: old 0x40 used
        LUT_WE = 1;
        LUT_SEL = 1;
        LUT_ADDR = 20;
        LUT_WDATA = 8'hFF;
        send(1, 20, 0, p31, pk(0, 0, 0, 0), 4'hF,
             pk(15, 15, 15, 15), 4'b0000, 1, 1);
        LUT_WE = 0;
        send(1, 20, 0, p31, pk(0, 0, 0, 0), 4'hF,
             pk(61, 61, 61, 61), 4'b0000, 0, 1);
        drain();

        bp_on = 1;
        for (int k = 0; k < 8; k++) begin
            send(1, 31, 0, p31, pk(k * 5, k + 1, -(k + 1), k * 16), 4'b0001,
                 pk(k * 5 + 31, k + 1, -(k + 1), k * 16), 4'b0000, 0, 1);
        end
        drain();
        bp_on = 0;
        tick(1);
        chk("sat_cnt_bp", 32'(SAT_CNT), 32'd5);

        // hold a clipping result, then clear on the same edge it retires
        rdy_req = 0;
        tick(2);
        send(1, 31, 0, p31, wb, 4'hF,
             pk(127, 31, -69, 127), 4'b1001, 0, 1);
        for (int i = 0; i < 20 && !OUT_VALID; i++) tick(1);
        chk("stall_valid", 32'(OUT_VALID), 32'd1);
        chk("sat_cnt_pre_clr", 32'(SAT_CNT), 32'd5);
        rdy_req = 1;
        SAT_CNT_CLR = 1;
        tick(1);
        SAT_CNT_CLR = 0;
        tick(1);
        chk("sat_cnt_clr_hs", 32'(SAT_CNT), 32'd0);
        drain();

        // reset with three transactions in flight
        send(1, 31, 0, p31, wb, 4'hF, '0, '0, 0, 0);
        send(1, 31, 0, p31, wb, 4'hF, '0, '0, 0, 0);
        IN_VALID = 1;
        RST = 1;
        tick(1);
        RST = 0;
        IN_VALID = 0;
        chk("rst2_wsyn_new", WSYN_NEW, 32'd0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("rst2_no_out", 32'(OUT_VALID), 32'd0);
            tick(1);
        end
        send(1, 31, 0, p31, wb, 4'hF,
             pk(127, 31, -69, 127), 4'b1001, 1, 1);
        drain();
        chk("sat_cnt_after_rst", 32'(SAT_CNT), 32'd2);

        SAT_CNT_CLR = 1;
        tick(1);
        SAT_CNT_CLR = 0;
        chk("sat_cnt_idle_clr", 32'(SAT_CNT), 32'd0);
        for (int k = 0; k < 16400; k++) begin
            send(1, 31, 0, p31, pk(127, 127, 127, 127), 4'hF,
                 pk(127, 127, 127, 127), 4'b1111, 0, 1);
        end
        drain();
        chk("sat_cnt_ceiling", 32'(SAT_CNT), 32'h0000FFFF);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
